// File: rtl/motion_axis.sv
// Single-axis sprite motion engine: tick timer, divided signed acceleration with
// terminal-velocity saturation, and a bounded position that clamps or wraps.
module motion_axis #(
    parameter int unsigned POS_W    = 8,
    parameter int unsigned VEL_W    = 4,
    parameter int unsigned PERIOD_W = 26,
    parameter int unsigned DIV_W    = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                load,
    input  logic [POS_W-1:0]    start_pos,
    input  logic [VEL_W-1:0]    start_vel,
    input  logic [PERIOD_W-1:0] period,
    input  logic [VEL_W-1:0]    acc,
    input  logic [DIV_W-1:0]    acc_div,
    input  logic [VEL_W-2:0]    vmax,
    input  logic [POS_W-1:0]    lo,
    input  logic [POS_W-1:0]    hi,
    input  logic                wrap,
    output logic                tick,
    output logic [POS_W-1:0]    pos,
    output logic [VEL_W-1:0]    vel,
    output logic                hit_lo,
    output logic                hit_hi
);

    localparam int unsigned SW = POS_W + 2;
    localparam int unsigned AW = VEL_W + 1;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [VEL_W-1:0]    vel_q, vel_d;
    logic                tick_q, tick_d;
    logic                hit_lo_q, hit_lo_d;
    logic                hit_hi_q, hit_hi_d;

    logic signed [SW-1:0] sum, lo_s, hi_s, span;
    logic signed [AW-1:0] vel_sum, vmax_s, vel_clip;
    logic                 vel_neg, vel_pos;

    always_comb begin
        lo_s    = signed'({2'b00, lo});
        hi_s    = signed'({2'b00, hi});
        span    = hi_s - lo_s + SW'(1);
        sum     = signed'({2'b00, pos_q}) +
                  signed'({{(SW - VEL_W){vel_q[VEL_W-1]}}, vel_q});
        vel_neg = vel_q[VEL_W-1];
        vel_pos = !vel_q[VEL_W-1] && (vel_q != '0);

        // One extra bit of headroom so vel+acc never wraps before saturation.
        vel_sum = signed'({vel_q[VEL_W-1], vel_q}) + signed'({acc[VEL_W-1], acc});
        vmax_s  = signed'({2'b00, vmax});
        if (vel_sum > vmax_s) begin
            vel_clip = vmax_s;
        end else if (vel_sum < -vmax_s) begin
            vel_clip = -vmax_s;
        end else begin
            vel_clip = vel_sum;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_cnt_d = acc_cnt_q;
        pos_d     = pos_q;
        vel_d     = vel_q;
        tick_d    = 1'b0;
        hit_lo_d  = 1'b0;
        hit_hi_d  = 1'b0;

        if (load) begin
            cnt_d     = '0;
            acc_cnt_d = '0;
            pos_d     = start_pos;
            vel_d     = start_vel;
        end else if (enable) begin
            if (cnt_q >= period) begin
                cnt_d  = '0;
                tick_d = 1'b1;

                if (acc_cnt_q == acc_div) begin
                    acc_cnt_d = '0;
                    vel_d     = VEL_W'(vel_clip);
                end else begin
                    acc_cnt_d = acc_cnt_q + DIV_W'(1);
                end

                // Bound handling comes last so a clamp overrides the acceleration result.
                if (sum < lo_s) begin
                    hit_lo_d = 1'b1;
                    if (wrap) begin
                        pos_d = POS_W'(sum + span);
                    end else begin
                        pos_d = lo;
                        vel_d = '0;
                    end
                end else if (sum > hi_s) begin
                    hit_hi_d = 1'b1;
                    if (wrap) begin
                        pos_d = POS_W'(sum - span);
                    end else begin
                        pos_d = hi;
                        vel_d = '0;
                    end
                end else begin
                    pos_d = POS_W'(sum);
                    if (sum == lo_s && vel_neg) begin
                        hit_lo_d = 1'b1;
                        if (!wrap) vel_d = '0;
                    end
                    if (sum == hi_s && vel_pos) begin
                        hit_hi_d = 1'b1;
                        if (!wrap) vel_d = '0;
                    end
                end
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            acc_cnt_q <= '0;
            pos_q     <= '0;
            vel_q     <= '0;
            tick_q    <= 1'b0;
            hit_lo_q  <= 1'b0;
            hit_hi_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_cnt_q <= acc_cnt_d;
            pos_q     <= pos_d;
            vel_q     <= vel_d;
            tick_q    <= tick_d;
            hit_lo_q  <= hit_lo_d;
            hit_hi_q  <= hit_hi_d;
        end
    end

    assign tick   = tick_q;
    assign pos    = pos_q;
    assign vel    = vel_q;
    assign hit_lo = hit_lo_q;
    assign hit_hi = hit_hi_q;

endmodule

// File: tb/tb_motion_axis.sv
// Scoreboarded bench for motion_axis: stimulus pushes expected tick results,
// a negedge monitor pops and compares them whenever the DUT ticks.
module tb_motion_axis;

    localparam int unsigned POS_W    = 8;
    localparam int unsigned VEL_W    = 4;
    localparam int unsigned PERIOD_W = 26;
    localparam int unsigned DIV_W    = 4;

    logic                clk;
    logic                resetn;
    logic                enable;
    logic                load;
    logic [POS_W-1:0]    start_pos;
    logic [VEL_W-1:0]    start_vel;
    logic [PERIOD_W-1:0] period;
    logic [VEL_W-1:0]    acc;
    logic [DIV_W-1:0]    acc_div;
    logic [VEL_W-2:0]    vmax;
    logic [POS_W-1:0]    lo;
    logic [POS_W-1:0]    hi;
    logic                wrap;
    logic                tick;
    logic [POS_W-1:0]    pos;
    logic [VEL_W-1:0]    vel;
    logic                hit_lo;
    logic                hit_hi;

    motion_axis #(
        .POS_W    (POS_W),
        .VEL_W    (VEL_W),
        .PERIOD_W (PERIOD_W),
        .DIV_W    (DIV_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .load      (load),
        .start_pos (start_pos),
        .start_vel (start_vel),
        .period    (period),
        .acc       (acc),
        .acc_div   (acc_div),
        .vmax      (vmax),
        .lo        (lo),
        .hi        (hi),
        .wrap      (wrap),
        .tick      (tick),
        .pos       (pos),
        .vel       (vel),
        .hit_lo    (hit_lo),
        .hit_hi    (hit_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pos;
        logic [3:0] vel;
        logic       hl;
        logic       hh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [3:0] v, input logic hl, input logic hh);
        exp_t e;
        e.pos = p;
        e.vel = v;
        e.hl  = hl;
        e.hh  = hh;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load leaves enable high so counting starts on the following edge.
    task automatic do_load(input logic [7:0] sp, input logic [3:0] sv);
        start_pos = sp;
        start_vel = sv;
        load      = 1'b1;
        enable    = 1'b1;
        step(1);
        load      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (tick) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", {31'd0, tick}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tick_pos", {24'd0, pos}, {24'd0, mon_e.pos});
                    check("tick_vel", {28'd0, vel}, {28'd0, mon_e.vel});
                    check("tick_hit_lo", {31'd0, hit_lo}, {31'd0, mon_e.hl});
                    check("tick_hit_hi", {31'd0, hit_hi}, {31'd0, mon_e.hh});
                end
            end else begin
                check("idle_hits", {30'd0, hit_lo, hit_hi}, 32'd0);
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        start_pos = '0;
        start_vel = '0;
        period    = 26'd4;
        acc       = '0;
        acc_div   = '0;
        vmax      = 3'd7;
        lo        = 8'd0;
        hi        = 8'd255;
        wrap      = 1'b0;

        step(2);
        check("rst_pos", {24'd0, pos}, 32'd0);
        check("rst_vel", {28'd0, vel}, 32'd0);
        check("rst_pulses", {29'd0, tick, hit_lo, hit_hi}, 32'd0);
        resetn = 1'b1;
        step(1);

        // Constant velocity, tick every 5 cycles.
        push(8'd13, 4'd3, 1'b0, 1'b0);
        push(8'd16, 4'd3, 1'b0, 1'b0);
        push(8'd19, 4'd3, 1'b0, 1'b0);
        do_load(8'd10, 4'd3);
        for (int i = 1; i <= 15; i++) begin
            step(1);
            check("t1_tick_spacing", {31'd0, tick}, (i % 5 == 0) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;

        // Gravity with divided acceleration saturating at vmax=5.
        period  = 26'd0;
        acc     = 4'd1;
        acc_div = 4'd1;
        vmax    = 3'd5;
        hi      = 8'd200;
        push(8'd0,  4'd0, 1'b0, 1'b0);
        push(8'd0,  4'd1, 1'b0, 1'b0);
        push(8'd1,  4'd1, 1'b0, 1'b0);
        push(8'd2,  4'd2, 1'b0, 1'b0);
        push(8'd4,  4'd2, 1'b0, 1'b0);
        push(8'd6,  4'd3, 1'b0, 1'b0);
        push(8'd9,  4'd3, 1'b0, 1'b0);
        push(8'd12, 4'd4, 1'b0, 1'b0);
        push(8'd16, 4'd4, 1'b0, 1'b0);
        push(8'd20, 4'd5, 1'b0, 1'b0);
        push(8'd25, 4'd5, 1'b0, 1'b0);
        push(8'd30, 4'd5, 1'b0, 1'b0);
        push(8'd35, 4'd5, 1'b0, 1'b0);
        push(8'd40, 4'd5, 1'b0, 1'b0);
        do_load(8'd0, 4'd0);
        step(14);
        enable = 1'b0;
        check("t2_vel_saturated", {28'd0, vel}, 32'd5);

        // Clamp at hi, then rest against the bound with no further hits.
        period  = 26'd1;
        acc     = 4'd0;
        acc_div = 4'd0;
        vmax    = 3'd7;
        hi      = 8'd100;
        push(8'd100, 4'd0, 1'b0, 1'b1);
        push(8'd100, 4'd0, 1'b0, 1'b0);
        push(8'd100, 4'd0, 1'b0, 1'b0);
        do_load(8'd98, 4'd4);
        step(6);
        enable = 1'b0;

        // Landing exactly on lo while moving down: hit and stop in clamp mode.
        period = 26'd0;
        push(8'd0, 4'd0, 1'b1, 1'b0);
        push(8'd0, 4'd0, 1'b0, 1'b0);
        do_load(8'd5, 4'hB);
        step(2);
        enable = 1'b0;

        // Wrap below lo and above hi on a 160-wide playfield.
        wrap = 1'b1;
        hi   = 8'd159;
        push(8'd157, 4'hB, 1'b1, 1'b0);
        push(8'd152, 4'hB, 1'b0, 1'b0);
        do_load(8'd2, 4'hB);
        step(2);
        enable = 1'b0;
        push(8'd1, 4'd3, 1'b0, 1'b1);
        do_load(8'd158, 4'd3);
        step(1);
        enable = 1'b0;

        // Freeze mid-count, then load must beat a pending tick.
        wrap   = 1'b0;
        hi     = 8'd255;
        period = 26'd4;
        do_load(8'd50, 4'd1);
        step(2);
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("t5_frozen_pos", {24'd0, pos}, 32'd50);
            check("t5_frozen_tick", {31'd0, tick}, 32'd0);
        end
        check("t5_frozen_vel", {28'd0, vel}, 32'd1);
        enable = 1'b1;
        step(2);
        start_pos = 8'd70;
        start_vel = 4'd2;
        load      = 1'b1;
        step(1);
        load = 1'b0;
        check("t5_load_no_tick", {31'd0, tick}, 32'd0);
        check("t5_load_pos", {24'd0, pos}, 32'd70);
        check("t5_load_vel", {28'd0, vel}, 32'd2);
        push(8'd72, 4'd2, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("t5_tick_after_load", {31'd0, tick}, (i == 5) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;

        // Asynchronous reset between edges mid-count.
        period = 26'd3;
        do_load(8'd30, 4'd2);
        step(2);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_async_pos", {24'd0, pos}, 32'd0);
        check("t6_async_vel", {28'd0, vel}, 32'd0);
        check("t6_async_pulses", {29'd0, tick, hit_lo, hit_hi}, 32'd0);
        #2;
        resetn = 1'b1;
        push(8'd0, 4'd0, 1'b0, 1'b0);
        step(1);
        check("t6_no_tick_after_release", {31'd0, tick}, 32'd0);
        check("t6_pos_after_release", {24'd0, pos}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check("t6_first_tick", {31'd0, tick}, (i == 3) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;
        step(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motion_axis.md
# motion_axis

Parametrised single-axis motion engine for sprite kinematics. It combines a programmable tick timer, a velocity register with signed, divided acceleration and symmetric terminal-velocity saturation, and a bounded position register that either clamps or wraps at the playfield edges. One instance per axis (x, y) replaces separate timer, coordinate and acceleration counters, and feeds the drawing FSM with position plus boundary-hit pulses.

## Interface
- POS_W, 8, position width (unsigned)
- VEL_W, 4, velocity width (signed two's complement)
- PERIOD_W, 26, tick-period counter width
- DIV_W, 4, acceleration divider width
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- enable  in  1  advance tick counter; low freezes all state
- load  in  1  synchronous load of start state; priority over enable
- start_pos  in  POS_W  position loaded on load
- start_vel  in  VEL_W  signed velocity loaded on load
- period  in  PERIOD_W  tick every period+1 enabled cycles
- acc  in  VEL_W  signed acceleration added to velocity per divided tick
- acc_div  in  DIV_W  acceleration applied every acc_div+1 ticks
- vmax  in  VEL_W-1  velocity magnitude limit (unsigned, ≤ 2^(VEL_W-1)-1)
- lo, hi  in  POS_W  inclusive bounds, lo ≤ hi
- wrap  in  1  0 = clamp at bounds, 1 = wrap lo↔hi
- tick  out  1  one-cycle pulse, registered
- pos  out  POS_W  current position
- vel  out  VEL_W  current signed velocity
- hit_lo, hit_hi  out  1  one-cycle pulse on crossing/reaching bound, registered

## Operation
- Reset (async, resetn=0): cnt=0, acc_cnt=0, pos=0, vel=0, tick=0, hit_lo=0, hit_hi=0.
- tick, hit_lo, hit_hi default to 0 every cycle; each is high for exactly one cycle per event.
- load=1: pos←start_pos, vel←start_vel, cnt←0, acc_cnt←0; no tick or hit pulse that cycle; enable ignored.
- enable=0, load=0: everything holds (cnt, acc_cnt, pos, vel).
- enable=1: if cnt ≥ period → cnt←0, tick←1, perform update; else cnt←cnt+1. period change mid-count with cnt > period fires on next enabled cycle.
- Update on tick, using pre-update pos and vel:
  - sum = pos + sign-extend(vel), computed signed at POS_W+2 bits.
  - sum < lo: clamp → pos←lo, vel←0, hit_lo←1; wrap → pos←sum+(hi−lo+1), hit_lo←1, vel continues.
  - sum > hi: clamp → pos←hi, vel←0, hit_hi←1; wrap → pos←sum−(hi−lo+1), hit_hi←1.
  - sum = lo with vel<0 or sum = hi with vel>0: pos←sum, hit pulse raised; clamp mode zeroes vel.
  - otherwise pos←sum.
  - Acceleration: if acc_cnt = acc_div → acc_cnt←0, vel←sat(vel+acc, −vmax, +vmax), else acc_cnt←acc_cnt+1. Addition at VEL_W+1 bits, no overflow wrap.
  - Clamp-bound vel←0 overrides the acceleration result on the same tick; acc_cnt still advances/resets.
- Wrap assumes |vel| ≤ hi−lo+1; larger values are out of contract.
- pos starting outside [lo,hi] is corrected on the next tick by the same rules.

## Timing
- tick, pos, vel, hit_* all update on the same edge (cnt = period sampled); visible the following cycle.
- Tick interval: period+1 enabled cycles; first tick after load is period+1 enabled cycles after load cycle.
- Velocity changes every (acc_div+1)·(period+1) enabled cycles.
- Reset mid-operation takes effect immediately (asynchronous); first tick after release is period+1 enabled cycles later.
- No combinational input-to-output paths.

## Test plan
- Reset then load start_pos=10, start_vel=+3, period=4, acc=0, enable=1 → tick every 5 cycles; pos 13, 16, 19; vel stays 3; no hit pulses.
- Gravity: start_vel=0, acc=+1, acc_div=1, vmax=5, period=0, lo=0, hi=200 → vel 0,1,1,2,2,… saturates at 5, never 6; pos accumulates using pre-update vel.
- Clamp: wrap=0, lo=0, hi=100, pos=98, vel=+4 → next tick pos=100, vel=0, hit_hi one cycle; later ticks with acc=0 keep pos=100 and no further hits.
- Wrap: wrap=1, lo=0, hi=159, pos=2, vel=−5 → pos=157, hit_lo one cycle, vel=−5 kept.
- enable toggled low for 7 cycles mid-count, then load asserted together with enable → state frozen while low; load wins, cnt=0, no tick that cycle.
- resetn pulsed low between clock edges mid-count → all outputs 0 immediately, no tick on the next edge.
